// File: rtl/div_ctrl.sv
// div_ctrl: iterative 32-step restoring divider controller for the EXE stage.
// Owns the shared divider. It accepts one DIV/DIVU per handshake and holds the
// quotient (lo) and remainder (hi) until the HI/LO writer consumes them.
module div_ctrl #(
    parameter int STEPS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        in_sign,
    input  logic [31:0] in_dividend,
    input  logic [31:0] in_divisor,
    input  logic        flush,
    output logic        div_allowin,
    output logic        busy,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_lo,
    output logic [31:0] out_hi
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [32:0] rem;        // 33 bits so the shifted partial remainder never overflows
    logic [31:0] quo;
    logic [31:0] dvs;        // |divisor|
    logic [31:0] dvd_raw;    // original dividend, returned as remainder on divide-by-zero
    logic        q_neg;
    logic        r_neg;
    logic        dvs_zero;

    logic        accept;
    logic [32:0] rem_sh;
    logic [32:0] trial;
    logic [31:0] abs_dvd;
    logic [31:0] abs_dvs;

    assign div_allowin = (state == IDLE) || (state == DONE && out_ready);
    assign busy        = (state == CALC) || (state == FIX);
    assign out_valid   = (state == DONE);
    assign accept      = in_valid && div_allowin && !flush;

    // One restoring step: shift {rem,quo} left and try subtracting the divisor.
    always_comb begin
        rem_sh  = {rem[31:0], quo[31]};
        trial   = rem_sh - {1'b0, dvs};
        abs_dvd = (in_sign && in_dividend[31]) ? (~in_dividend + 32'd1) : in_dividend;
        abs_dvs = (in_sign && in_divisor[31])  ? (~in_divisor + 32'd1)  : in_divisor;
    end

    // Controller FSM and datapath registers; flush dominates everything but rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            dvd_raw  <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            dvs_zero <= 1'b0;
            out_lo   <= '0;
            out_hi   <= '0;
        end else if (flush) begin
            state <= IDLE;
        end else if (accept) begin
            // Accept covers both IDLE and the no-bubble DONE->CALC handoff.
            state    <= CALC;
            cnt      <= '0;
            rem      <= '0;
            quo      <= abs_dvd;
            dvs      <= abs_dvs;
            dvd_raw  <= in_dividend;
            q_neg    <= in_sign && (in_dividend[31] ^ in_divisor[31]);
            r_neg    <= in_sign && in_dividend[31];
            dvs_zero <= (in_divisor == 32'd0);
        end else begin
            case (state)
                CALC: begin
                    if (!trial[32]) begin
                        rem <= trial;
                        quo <= {quo[30:0], 1'b1};
                    end else begin
                        rem <= rem_sh;
                        quo <= {quo[30:0], 1'b0};
                    end
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'(STEPS - 1)) state <= FIX;
                end
                FIX: begin
                    // Divide-by-zero result is architecturally fixed regardless of sign.
                    if (dvs_zero) begin
                        out_lo <= 32'hFFFF_FFFF;
                        out_hi <= dvd_raw;
                    end else begin
                        out_lo <= q_neg ? (~quo + 32'd1) : quo;
                        out_hi <= r_neg ? (~rem[31:0] + 32'd1) : rem[31:0];
                    end
                    state <= DONE;
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
